float_divider_e4m3: RTL and testbench

- Iterative sequential floating-point divider, y = a / b. It is the inverse-operation companion to the team's fp8/bf16 multipliers and sits alongside them in the arithmetic datapath.
- Default format is e4m3 (1 sign, 4 exponent, 3 mantissa bits); exponent and mantissa widths are parameterised.
- Mantissas are divided by a restoring divider at one quotient bit per cycle, then normalised and truncated.
- Start/busy/valid handshake; one operation in flight.

---
 rtl/float_divider_e4m3.sv | 159 +++++++++++++++
 tb/tb_float_divider_e4m3.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_divider_e4m3.sv
// Iterative e4m3 floating-point divider y = a / b: restoring mantissa divide
// at one quotient bit per cycle, then normalise, truncate, saturate or flush.
module float_divider_e4m3 #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 7
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   busy,
  output logic                   is_output_valid,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   div_by_zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 2;
  localparam int CW = $clog2(QW);
  localparam int XW = EXP_W + 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_NORM   = 2'd2;

  localparam logic signed [XW-1:0] L_BIAS = XW'(BIAS);
  localparam logic signed [XW-1:0] L_ONE  = XW'(1);
  localparam logic signed [XW-1:0] L_EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [MAN_W-1:0]     L_MAN_SAT = ~MAN_W'(1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [QW-1:0]    r_rem;
  logic [QW-1:0]    r_q;
  logic [MAN_W:0]   r_div;
  logic             r_sign;
  logic [EXP_W-1:0] r_ae;
  logic [EXP_W-1:0] r_be;
  logic [W-1:0]     r_y;
  logic             r_valid;
  logic             r_ovf;
  logic             r_udf;
  logic             r_dz;

  logic             w_sign;
  logic [EXP_W-1:0] w_a_e;
  logic [EXP_W-1:0] w_b_e;
  logic [MAN_W-1:0] w_a_m;
  logic [MAN_W-1:0] w_b_m;
  logic             w_ge;
  logic [QW-1:0]    w_rem_next;
  logic signed [XW-1:0] w_e_raw;
  logic signed [XW-1:0] w_e;
  logic [MAN_W-1:0] w_man;
  logic             w_ovf;
  logic             w_udf;

  always_comb begin
    w_sign = a[W-1] ^ b[W-1];
    w_a_e  = a[W-2:MAN_W];
    w_b_e  = b[W-2:MAN_W];
    w_a_m  = a[MAN_W-1:0];
    w_b_m  = b[MAN_W-1:0];
  end

  // R stays below 2*B after each step, so the shifted value never loses its MSB.
  always_comb begin
    w_ge       = (r_rem >= {1'b0, r_div});
    w_rem_next = w_ge ? ((r_rem - {1'b0, r_div}) << 1) : (r_rem << 1);
  end

  // One guard bit beyond the signed exponent catches raw wrap for any BIAS.
  always_comb begin
    w_e_raw = $signed({3'b000, r_ae}) - $signed({3'b000, r_be}) + L_BIAS;
    w_e     = r_q[QW-1] ? w_e_raw : (w_e_raw - L_ONE);
    w_man   = r_q[QW-1] ? r_q[MAN_W:1] : r_q[MAN_W-1:0];
    w_ovf   = (w_e >= L_EMAX);
    w_udf   = w_e[XW-1] || (w_e == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_sign  <= 1'b0;
      r_ae    <= '0;
      r_be    <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign  <= w_sign;
            r_ae    <= w_a_e;
            r_be    <= w_b_e;
            r_div   <= {1'b1, w_b_m};
            r_rem   <= {1'b0, 1'b1, w_a_m};
            r_q     <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            if (w_b_e == '0) begin
              r_y     <= {w_sign, {(W-1){1'b1}}};
              r_dz    <= 1'b1;
              r_valid <= 1'b1;
            end else if (w_a_e == '0) begin
              r_y     <= {w_sign, {(W-1){1'b0}}};
              r_dz    <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_dz    <= 1'b0;
              r_valid <= 1'b0;
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(QW-1)) r_state <= S_NORM;
        end
        S_NORM: begin
          if (w_ovf) begin
            r_y   <= {r_sign, {EXP_W{1'b1}}, L_MAN_SAT};
            r_ovf <= 1'b1;
          end else if (w_udf) begin
            r_y   <= {r_sign, {(W-1){1'b0}}};
            r_udf <= 1'b1;
          end else begin
            r_y   <= {r_sign, w_e[EXP_W-1:0], w_man};
          end
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign y               = r_y;
  assign busy            = (r_state != S_IDLE);
  assign is_output_valid = r_valid;
  assign overflow        = r_ovf;
  assign underflow       = r_udf;
  assign div_by_zero     = r_dz;

endmodule

// File: tb/tb_float_divider_e4m3.sv
// Bench for float_divider_e4m3: arithmetic reference model plus cycle-level
// handshake model, directed literal cases and randomized operand pairs.
module tb_float_divider_e4m3;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] a       = 8'h00;
  logic [7:0] b       = 8'h00;
  logic [7:0] y;
  logic       busy;
  logic       is_output_valid;
  logic       overflow;
  logic       underflow;
  logic       div_by_zero;

  float_divider_e4m3 #(.EXP_W(4), .MAN_W(3), .BIAS(7)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .a               (a),
    .b               (b),
    .y               (y),
    .busy            (busy),
    .is_output_valid (is_output_valid),
    .overflow        (overflow),
    .underflow       (underflow),
    .div_by_zero     (div_by_zero)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Value-level reference: quotient of the significands, truncated to 3 bits.
  function automatic void ref_div(input logic [7:0] ra, input logic [7:0] rb,
                                  output logic [7:0] ry, output logic ov,
                                  output logic uf, output logic dz);
    int ae, be, sig_a, sig_b, q, e, man;
    logic s;
    s  = ra[7] ^ rb[7];
    ae = int'(ra[6:3]);
    be = int'(rb[6:3]);
    sig_a = 8 + int'(ra[2:0]);
    sig_b = 8 + int'(rb[2:0]);
    ov = 1'b0; uf = 1'b0; dz = 1'b0;
    if (be == 0) begin
      ry = {s, 7'h7F};
      dz = 1'b1;
    end else if (ae == 0) begin
      ry = {s, 7'h00};
    end else begin
      q = (sig_a * 16) / sig_b;
      if (q >= 16) begin
        man = (q / 2) % 8;
        e   = ae - be + 7;
      end else begin
        man = q % 8;
        e   = ae - be + 6;
      end
      if (e >= 15) begin
        ry = {s, 7'h7E};
        ov = 1'b1;
      end else if (e <= 0) begin
        ry = {s, 7'h00};
        uf = 1'b1;
      end else begin
        ry = {s, 4'(e), 3'(man)};
      end
    end
  endfunction

  function automatic logic is_special(input logic [7:0] ra, input logic [7:0] rb);
    return (rb[6:3] == 4'd0) || (ra[6:3] == 4'd0);
  endfunction

  // Handshake model: tracks what the outputs must show after each edge.
  int         m_busy  = 0;
  logic [7:0] m_y     = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ov = 1'b0, m_uf = 1'b0, m_dz = 1'b0;
  logic [7:0] p_y;
  logic       p_ov, p_uf, p_dz;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_y = 8'h00; m_valid = 1'b0;
      m_ov = 1'b0; m_uf = 1'b0; m_dz = 1'b0;
    end else if (m_busy == 0 && start) begin
      ref_div(a, b, p_y, p_ov, p_uf, p_dz);
      m_valid = 1'b0; m_ov = 1'b0; m_uf = 1'b0; m_dz = 1'b0;
      if (is_special(a, b)) begin
        m_y = p_y; m_dz = p_dz; m_valid = 1'b1;
      end else begin
        m_busy = 6;
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_y = p_y; m_ov = p_ov; m_uf = p_uf; m_dz = p_dz; m_valid = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    check("busy", busy, m_busy != 0);
    check("valid", is_output_valid, m_valid);
    check("flags", {overflow, underflow, div_by_zero}, {m_ov, m_uf, m_dz});
    if (m_valid) check("y", y, m_y);
  end

  // Caller is at posedge+2 with the DUT idle; returns at posedge+2.
  // lat counts edges after the accepting edge until valid is seen.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic poke,
                       output int lat);
    start = 1'b1; a = ta; b = tb;
    @(posedge clock); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    while (!is_output_valid && lat < 20) begin
      start = poke && (lat == 2);
      if (start) begin a = 8'h38; b = 8'h80; end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [7:0] ta;
    logic [7:0] tb;
    logic [7:0] ey;
    logic [2:0] efl;
    int         elat;
    logic       poke;
  } vec_t;

  vec_t vecs[$] = '{
    '{8'h40, 8'h38, 8'h40, 3'b000, 6, 1'b0},
    '{8'h38, 8'h3C, 8'h32, 3'b000, 6, 1'b0},
    '{8'hC4, 8'h3C, 8'hC0, 3'b000, 6, 1'b0},
    '{8'h00, 8'h38, 8'h00, 3'b000, 0, 1'b0},
    '{8'h38, 8'h80, 8'hFF, 3'b001, 0, 1'b0},
    '{8'h00, 8'h00, 8'h7F, 3'b001, 0, 1'b0},
    '{8'h70, 8'h08, 8'h7E, 3'b100, 6, 1'b0},
    '{8'hF0, 8'h08, 8'hFE, 3'b100, 6, 1'b0},
    '{8'h08, 8'h70, 8'h00, 3'b010, 6, 1'b0},
    '{8'h40, 8'h38, 8'h40, 3'b000, 6, 1'b1}
  };

  initial begin
    int lat;
    logic [7:0] ty;
    logic tov, tuf, tdz;
    logic [7:0] ra, rb;

    ref_div(8'h38, 8'h3C, ty, tov, tuf, tdz); check("model 1.0/1.5", ty, 8'h32);
    ref_div(8'hC4, 8'h3C, ty, tov, tuf, tdz); check("model -3.0/1.5", ty, 8'hC0);
    ref_div(8'h70, 8'h08, ty, tov, tuf, tdz); check("model ovf", {ty, tov}, {8'h7E, 1'b1});
    ref_div(8'h38, 8'h80, ty, tov, tuf, tdz); check("model dz", {ty, tdz}, {8'hFF, 1'b1});

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("reset y", y, 8'h00);
    check("reset busy/valid", {busy, is_output_valid}, 2'b00);
    check("reset flags", {overflow, underflow, div_by_zero}, 3'b000);
    reset_n = 1'b1;
    @(posedge clock); #2;

    do_op(8'h40, 8'h38, 1'b0, lat);
    check("first op y", y, 8'h40);

    // Abort an operation mid-divide.
    start = 1'b1; a = 8'h40; b = 8'h38;
    @(posedge clock); #2;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort y", y, 8'h00);
    check("abort busy/valid", {busy, is_output_valid}, 2'b00);
    @(posedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #2;

    foreach (vecs[i]) begin
      do_op(vecs[i].ta, vecs[i].tb, vecs[i].poke, lat);
      check($sformatf("vec%0d y", i), y, vecs[i].ey);
      check($sformatf("vec%0d flags", i), {overflow, underflow, div_by_zero}, vecs[i].efl);
      check($sformatf("vec%0d latency", i), lat, vecs[i].elat);
    end

    repeat (4) begin @(posedge clock); #2; end
    check("hold y", y, 8'h40);
    check("hold valid", is_output_valid, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clock); #2; end
      end
      do_op(ra, rb, $urandom_range(0, 9) == 0, lat);
      ref_div(ra, rb, ty, tov, tuf, tdz);
      check("rand y", y, ty);
      check("rand latency", lat, is_special(ra, rb) ? 0 : 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
